// File: rtl/bitty_seq_pkg.sv
// bitty_seq_pkg: shared types and constants for the bitty instruction sequencer.
// The watchdog build option is BITTY_SEQ_WDT_EN (see bitty_seq.sv).
package bitty_seq_pkg;

    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] DEFAULT_HALT_OPCODE = 16'hFFFF;

    localparam logic [INSTR_W-1:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_EXEC   = 3'd3,
        S_RETIRE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/bitty_seq_wdt.sv
// bitty_seq_wdt: loadable down-counter guarding the EXEC wait.
// Load arms it with COUNT-1, each enabled cycle counts down, and o_expired
// is high once it reaches zero (i.e. on the COUNT-th enabled cycle).
module bitty_seq_wdt #(
    parameter int COUNT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(COUNT - 1);

    logic [CW-1:0] r_cnt;

    // Count down while enabled; load has priority over clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/bitty_seq.sv
// bitty_seq: fetches 16-bit words from instruction memory (req/ack), issues
// them to the bitty core (run/done), captures d_out and steps the pc until a
// halt opcode or the programmed last address.
// Build option: define BITTY_SEQ_WDT_EN to add the EXEC watchdog (err output).
//
// Handshakes: mem_req/mem_addr are held stable until a cycle in which mem_ack
// is high; that cycle's mem_rdata is consumed at the clock edge (an ack in the
// first request cycle is legal). cpu_run is a one-cycle pulse; the first
// cpu_done seen in EXEC (never in ISSUE) completes the instruction.
module bitty_seq
    import bitty_seq_pkg::*;
#(
    parameter int                 PC_W        = 8,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE,
    parameter int                 WDT_CYCLES  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic [PC_W-1:0]    last_addr,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] cpu_instr,
    output logic               cpu_run,
    input  logic               cpu_done,
    input  logic [INSTR_W-1:0] cpu_dout,
    output logic [INSTR_W-1:0] result,
    output logic               result_valid,
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr_count,
    output logic               err,
    output logic [2:0]         dbg_state
);

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_last;
    logic [INSTR_W-1:0]   r_instr;
    logic [INSTR_W-1:0]   r_result;
    logic [INSTR_W-1:0]   r_count;
    logic                 r_mem_req;
    logic                 r_run;
    logic                 r_rv;
    logic                 r_busy;
    logic                 r_halted;

`ifdef BITTY_SEQ_WDT_EN
    logic r_err;
    logic w_wdt_expired;
    logic w_timeout;

    bitty_seq_wdt #(
        .COUNT(WDT_CYCLES)
    ) u_wdt (
        .clk       (clk),
        .reset     (reset),
        .i_clear   ((r_state == S_IDLE) || (r_state == S_HALT)),
        .i_load    (r_state == S_ISSUE),
        .i_en      (r_state == S_EXEC),
        .o_expired (w_wdt_expired)
    );

    assign w_timeout = (r_state == S_EXEC) && !cpu_done && w_wdt_expired;
    assign err       = r_err;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = ^WDT_CYCLES;
    assign err          = 1'b0;
`endif

    // Sequencer FSM; every output is a register set on the transition into
    // the state that owns it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_last    <= '0;
            r_instr   <= '0;
            r_result  <= '0;
            r_count   <= '0;
            r_mem_req <= 1'b0;
            r_run     <= 1'b0;
            r_rv      <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
`ifdef BITTY_SEQ_WDT_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_run <= 1'b0;
            r_rv  <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc      <= start_addr;
                        r_last    <= last_addr;
                        r_count   <= '0;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_halted  <= 1'b0;
                        r_state   <= S_FETCH;
`ifdef BITTY_SEQ_WDT_EN
                        r_err     <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (mem_rdata == HALT_OPCODE) begin
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_instr <= mem_rdata;
                            r_run   <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (cpu_done) begin
                        r_result <= cpu_dout;
                        r_rv     <= 1'b1;
                        if (r_count != COUNT_MAX) begin
                            r_count <= r_count + 16'd1;
                        end
                        r_state  <= S_RETIRE;
                    end
`ifdef BITTY_SEQ_WDT_EN
                    else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end
`endif
                end
                S_RETIRE: begin
                    if (r_pc == r_last) begin
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_pc      <= r_pc + 1'b1;
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_halted  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_pc;
    assign cpu_instr    = r_instr;
    assign cpu_run      = r_run;
    assign result       = r_result;
    assign result_valid = r_rv;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign pc           = r_pc;
    assign instr_count  = r_count;
    assign dbg_state    = r_state;

endmodule
